// File: rtl/dispatch_queue.sv
// dispatch_queue: in-order buffer from decode to the per-class FU issue ports.
// Ports: clock/reset/flush; in_valid/in_packet/in_fu_class/in_ready from decode;
// fu_ready, out_valid (one-hot), out_packet, out_fu_class, illegal_drop, count.
// Optional same-cycle bypass into an empty queue: DISPATCH_QUEUE_BYPASS_EN.
package dispatch_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } if_id_t;
endpackage

module dispatch_queue
  import dispatch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  if_id_t           in_packet,
  input  logic [2:0]       in_fu_class,
  output logic             in_ready,
  input  logic [4:0]       fu_ready,
  output logic [4:0]       out_valid,
  output if_id_t           out_packet,
  output logic [2:0]       out_fu_class,
  output logic             illegal_drop,
  output logic [CNT_W-1:0] count
);

  if_id_t     pkt_q [DEPTH];
  logic [2:0] cls_q [DEPTH];

  logic [PTR_W-1:0] head_ptr;
  logic [PTR_W-1:0] tail_ptr;

  logic       empty;
  logic       full;
  logic       enq;
  logic       deq;
  logic       byp;
  logic [2:0] head_cls;
  logic [4:0] q_valid;
  logic [7:0] rdy_ext;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign head_cls = cls_q[head_ptr];
  assign rdy_ext  = {3'b000, fu_ready};
  assign in_ready = !full && !flush;

  // Classes 5..7 read zero from rdy_ext, so they never dispatch.
  always_comb begin
    q_valid = '0;
    for (int c = 0; c < 5; c++) begin
      q_valid[c] = !empty && !flush &&
                   (head_cls == 3'(c)) &&
                   fu_ready[c];
    end
  end

`ifdef DISPATCH_QUEUE_BYPASS_EN
  assign byp = empty && in_valid && !flush &&
               (in_fu_class <= 3'd4) &&
               rdy_ext[in_fu_class];
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    out_valid    = q_valid;
    out_packet   = pkt_q[head_ptr];
    out_fu_class = head_cls;
    illegal_drop = !empty && !flush &&
                   (head_cls >= 3'd5);
    enq          = in_valid && in_ready;
    deq          = (|q_valid) || illegal_drop;
    if (byp) begin
      // Bypassed entry never touches storage.
      out_valid    = 5'(rdy_ext[in_fu_class])
                     << in_fu_class;
      out_packet   = in_packet;
      out_fu_class = in_fu_class;
      enq          = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (enq) tail_ptr <= tail_ptr + 1'b1;
      if (deq) head_ptr <= head_ptr + 1'b1;
      count <= count + CNT_W'(enq)
                     - CNT_W'(deq);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && enq) begin
      pkt_q[tail_ptr] <= in_packet;
      cls_q[tail_ptr] <= in_fu_class;
    end
  end

endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
- In-order buffer between the opcode/FU-class decode stage and the functional-unit issue ports.
- Each entry holds one decoded IF_ID_PACKET and its 3-bit FU class.
- The head entry is routed to the one functional unit its class selects, with a per-class ready/valid handshake.
- Absorbs FU back-pressure and drops entries with an undefined class. Flushable on branch mispredict.

Parameters:
- DEPTH, 8, number of entries; power of 2, at least 2.
- PTR_W, $clog2(DEPTH), width of the head/tail pointers.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy counter.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- flush  input  1  squash all entries (mispredict); synchronous.
- in_valid  input  1  decode stage offers an entry.
- in_packet  input  IF_ID_PACKET  decoded instruction packet.
- in_fu_class  input  3  0=ALU, 1=MULT, 2=BRANCH/JUMP, 3=LOAD, 4=STORE, 7=none/invalid.
- in_ready  output  1  queue accepts the entry this cycle.
- fu_ready  input  5  bit c = FU class c can accept an instruction this cycle.
- out_valid  output  5  one-hot; bit c = head is dispatched to class c this cycle.
- out_packet  output  IF_ID_PACKET  head packet; valid only when out_valid != 0.
- out_fu_class  output  3  head class.
- illegal_drop  output  1  head carried class 5/6/7 and is discarded this cycle.
- count  output  CNT_W  current occupancy.

Behaviour:
- Storage: circular buffer with head_ptr, tail_ptr and count registers. Pointers wrap from DEPTH-1 to 0.
- empty = (count==0); full = (count==DEPTH).
- Reset (synchronous, clock edge with reset=1):
  - head_ptr, tail_ptr and count go to 0.
  - Next cycle: out_valid=0, illegal_drop=0, count=0, in_ready=1.
  - Entry contents need not be cleared.
  - Reset overrides flush, enqueue and dispatch in the same cycle.
- in_ready = !full && !flush.
  - A same-cycle dequeue does not free a slot for enqueue when full, so there is no combinational in_ready←fu_ready path.
- Enqueue when in_valid && in_ready: write {in_packet, in_fu_class} at tail_ptr, increment tail_ptr.
- Dispatch (combinational from head and fu_ready):
  - out_valid[c] = !empty && !flush && head_class==c && fu_ready[c], for c in 0..4.
  - out_packet and out_fu_class always show the head entry.
  - If any out_valid bit is set, head_ptr increments at the clock edge.
- Illegal drop:
  - illegal_drop = !empty && !flush && head_class>=5.
  - The entry is popped in that cycle with no out_valid bit set and no fu_ready dependency.
- count_next = count + enq − deq, where deq = |out_valid || illegal_drop.
  - Simultaneous enqueue and dequeue leaves count unchanged.
  - A push into an empty queue is not visible at the head until the next cycle, so minimum latency is 1 cycle.
- Head blocking: if fu_ready[head_class]=0, the head stalls and younger entries wait. No reordering.
- Flush:
  - out_valid=0, illegal_drop=0 and in_ready=0 in the flush cycle.
  - At the edge, head_ptr=tail_ptr=0 and count=0. Any in_valid in that cycle is discarded.
- Full: in_ready=0 and any in_valid is ignored by the queue; the producer must hold the entry.
- Empty: out_valid=0 and illegal_drop=0 regardless of fu_ready.

Optional Feature:
- Macro: DISPATCH_QUEUE_BYPASS_EN.
- Defined:
  - When empty && in_valid && !flush && in_fu_class<=4 && fu_ready[in_fu_class], the incoming entry is dispatched in the same cycle.
  - out_packet/out_fu_class = in_packet/in_fu_class, out_valid[in_fu_class]=1, in_ready=1.
  - The entry is not written; pointers and count are unchanged.
  - An illegal class on the bypass path is enqueued normally, not dropped combinationally.
- Not defined: no in→out combinational path; minimum latency 1 cycle.

Test Plan:
- Reset, then push ADD (class 0) with fu_ready=5'b11111 → next cycle out_valid=5'b00001, out_packet matches, count 1→0.
- Push LW (class 3) with fu_ready[3]=0 for 4 cycles, plus 2 ALU ops behind it → head stalls, out_valid=0, count=3; raise fu_ready[3] → LW then the ALU ops dispatch in order over 3 cycles.
- Fill 8 entries with fu_ready=0 → count=8, in_ready=0, a 9th push is not accepted. Set fu_ready=5'b11111 while in_valid=1 → one dequeue per cycle; in_ready returns to 1 the cycle after the first dequeue; tail wraps from 7 to 0 correctly.
- Enqueue an entry with class 7 → illegal_drop=1 for one cycle, out_valid=0, count decrements.
- With 5 entries queued, assert flush together with in_valid=1 → out_valid=0 that cycle, count=0 next cycle, the flushed and concurrent entries never appear.
- With DISPATCH_QUEUE_BYPASS_EN defined: empty queue, in_valid=1, class 4, fu_ready[4]=1 → out_valid=5'b10000 in the same cycle, count stays 0. Without the macro → out_valid=5'b10000 one cycle later.
